// File: rtl/alu_seq_if.sv
// alu_if: operand request and result handshake bundle for alu_seq
interface alu_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] A, B, ALU_Out, ALU_Out_Hi;
  logic [3:0] ALU_Sel;
  logic in_valid, in_ready, out_valid, out_ready;
  logic CarryOut, Zero, Overflow;
  modport master (
    output A, B, ALU_Sel, in_valid, out_ready,
    input in_ready, ALU_Out, ALU_Out_Hi, CarryOut, Zero, Overflow, out_valid
  );
  modport slave (
    input A, B, ALU_Sel, in_valid, out_ready,
    output in_ready, ALU_Out, ALU_Out_Hi, CarryOut, Zero, Overflow, out_valid
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered handshaked ALU with iterative shift-add multiply
module alu_seq #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic reset,
  alu_if.slave io
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic {IDLE, MUL} state_t;
  state_t state, state_n;
  logic [2*WIDTH-1:0] mcand, acc, prod;
  logic [WIDTH-1:0] mplier, res, hi;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] sum, diff;
  logic c, v, accept, is_mul, done, load;
  assign io.in_ready = (state == IDLE) && (!io.out_valid || io.out_ready);
  assign accept = io.in_valid && io.in_ready;
  assign is_mul = io.ALU_Sel == 4'd2;
  assign done = (state == MUL) && (cnt == CW'(1));
  assign load = (accept && !is_mul) || done;
  assign sum = {1'b0, io.A} + {1'b0, io.B};
  assign diff = {1'b0, io.A} - {1'b0, io.B};
  assign prod = acc + (mplier[0] ? mcand : '0);
  always_comb begin
    res = '0;
    hi = '0;
    c = 1'b0;
    v = 1'b0;
    case (io.ALU_Sel)
      4'd0: begin
        res = sum[WIDTH-1:0];
        c = sum[WIDTH];
        v = (io.A[WIDTH-1] == io.B[WIDTH-1]) && (sum[WIDTH-1] != io.A[WIDTH-1]);
      end
      4'd1: begin
        res = diff[WIDTH-1:0];
        c = diff[WIDTH];
        v = (io.A[WIDTH-1] != io.B[WIDTH-1]) && (diff[WIDTH-1] != io.A[WIDTH-1]);
      end
      4'd3: begin
        res = {io.A[WIDTH-2:0], 1'b0};
        c = io.A[WIDTH-1];
      end
      4'd4: begin
        res = {1'b0, io.A[WIDTH-1:1]};
        c = io.A[0];
      end
      4'd5: res = {io.A[WIDTH-2:0], io.A[WIDTH-1]};
      4'd6: res = {io.A[0], io.A[WIDTH-1:1]};
      4'd7: res = io.A & io.B;
      4'd8: res = io.A | io.B;
      4'd9: res = io.A ^ io.B;
      4'd10: res = ~(io.A | io.B);
      4'd11: res = ~(io.A & io.B);
      4'd12: res = ~(io.A ^ io.B);
      4'd13: res = {{(WIDTH-1){1'b0}}, io.A > io.B};
      4'd14: res = {{(WIDTH-1){1'b0}}, io.A == io.B};
      4'd15: res = io.A;
      default: res = '0;
    endcase
    // the final multiply step lands the full product straight into the output registers
    if (state == MUL) begin
      res = prod[WIDTH-1:0];
      hi = prod[2*WIDTH-1:WIDTH];
      c = |prod[2*WIDTH-1:WIDTH];
      v = 1'b0;
    end
    state_n = (accept && is_mul) ? MUL : done ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      io.out_valid <= 1'b0;
      io.ALU_Out <= '0;
      io.ALU_Out_Hi <= '0;
      io.CarryOut <= 1'b0;
      io.Zero <= 1'b0;
      io.Overflow <= 1'b0;
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      if (io.out_valid && io.out_ready) io.out_valid <= 1'b0;
      if (load) begin
        io.out_valid <= 1'b1;
        io.ALU_Out <= res;
        io.ALU_Out_Hi <= hi;
        io.CarryOut <= c;
        io.Zero <= res == '0;
        io.Overflow <= v;
      end
      if (accept && is_mul) begin
        mcand <= {{WIDTH{1'b0}}, io.A};
        mplier <= io.B;
        acc <= '0;
        cnt <= CW'(WIDTH);
      end else if (state == MUL) begin
        acc <= prod;
        mcand <= mcand << 1;
        mplier <= mplier >> 1;
        cnt <= cnt - CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized scoreboard bench for alu_seq with directed corner cases
module tb_alu_seq;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  alu_if #(.WIDTH(8)) bus();
  alu_seq #(.WIDTH(8)) dut (.clk(clk), .reset(reset), .io(bus.slave));
  typedef struct packed {
    logic [7:0] hi;
    logic [7:0] lo;
    logic c;
    logic z;
    logic v;
  } resp_t;
  resp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  bit rand_bp = 1'b0;
  function automatic resp_t model(int a, int b, int sel);
    resp_t r;
    int x, h, sa, sbv, t;
    bit c, v;
    x = 0; h = 0; c = 1'b0; v = 1'b0;
    sa = a > 127 ? a - 256 : a;
    sbv = b > 127 ? b - 256 : b;
    case (sel)
      0: begin x = a + b; c = x > 255; t = sa + sbv; v = t > 127 || t < -128; end
      1: begin x = a - b; c = a < b; t = sa - sbv; v = t > 127 || t < -128; end
      2: begin x = a * b; h = x / 256; c = h != 0; end
      3: begin x = a * 2; c = a >= 128; end
      4: begin x = a / 2; c = (a % 2) == 1; end
      5: x = a * 2 + a / 128;
      6: x = a / 2 + (a % 2) * 128;
      7: x = a & b;
      8: x = a | b;
      9: x = a ^ b;
      10: x = ~(a | b);
      11: x = ~(a & b);
      12: x = ~(a ^ b);
      13: x = a > b ? 1 : 0;
      14: x = a == b ? 1 : 0;
      default: x = a;
    endcase
    x = x & 255;
    r.lo = x[7:0];
    r.hi = h[7:0];
    r.c = c;
    r.z = x == 0;
    r.v = v;
    return r;
  endfunction
  function automatic resp_t mk(logic [7:0] hi, logic [7:0] lo, logic c, logic z, logic v);
    return {hi, lo, c, z, v};
  endfunction
  function automatic resp_t cur();
    return {bus.ALU_Out_Hi, bus.ALU_Out, bus.CarryOut, bus.Zero, bus.Overflow};
  endfunction
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %0h required %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin : monitor
    resp_t exp;
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_result got %0h required none", cur());
      end else begin
        exp = sb.pop_front();
        check("scoreboard", 32'(cur()), 32'(exp));
      end
    end
  end
  always @(posedge clk) if (rand_bp) #1 bus.out_ready = 1'($urandom_range(0, 1));
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel, output int waits);
    waits = 0;
    bus.A = a;
    bus.B = b;
    bus.ALU_Sel = sel;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    if (!bus.in_ready) begin
      $display("FAIL accept_timeout got in_ready=0 required 1");
      $fatal(1, "accept timeout");
    end
    sb.push_back(model(int'(a), int'(b), int'(sel)));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.A = 8'($urandom);
    bus.B = 8'($urandom);
  endtask
  task automatic wait_result(output int n);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      check("mul_in_ready_low", 32'(bus.in_ready), 32'(0));
      @(posedge clk);
      #1;
      n++;
    end
  endtask
  function automatic logic [3:0] rand_non_mul();
    int s;
    s = $urandom_range(0, 14);
    if (s >= 2) s++;
    return s[3:0];
  endfunction
  initial begin
    #500000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int w, tw, n;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.A = '0;
    bus.B = '0;
    bus.ALU_Sel = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_out_valid", 32'(bus.out_valid), 32'(0));
    check("reset_outputs", 32'(cur()), 32'(0));
    check("reset_in_ready", 32'(bus.in_ready), 32'(1));
    issue(8'hFF, 8'h01, 4'd0, w);
    check("add_latency_valid", 32'(bus.out_valid), 32'(1));
    check("add_ff_01", 32'(cur()), 32'(mk(8'h00, 8'h00, 1'b1, 1'b1, 1'b0)));
    issue(8'h7F, 8'h01, 4'd0, w);
    check("add_7f_01", 32'(cur()), 32'(mk(8'h00, 8'h80, 1'b0, 1'b0, 1'b1)));
    issue(8'h05, 8'h07, 4'd1, w);
    check("sub_05_07", 32'(cur()), 32'(mk(8'h00, 8'hFE, 1'b1, 1'b0, 1'b0)));
    issue(8'hFF, 8'hFF, 4'd2, w);
    wait_result(n);
    check("mul_latency", 32'(n), 32'(8));
    check("mul_ff_ff", 32'(cur()), 32'(mk(8'hFE, 8'h01, 1'b1, 1'b0, 1'b0)));
    issue(8'h0F, 8'h03, 4'd2, w);
    wait_result(n);
    check("mul_latency2", 32'(n), 32'(8));
    check("mul_0f_03", 32'(cur()), 32'(mk(8'h00, 8'h2D, 1'b0, 1'b0, 1'b0)));
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    issue(8'h0F, 8'h33, 4'd7, w);
    repeat (3) begin
      check("bp_out_hold", 32'(bus.ALU_Out), 32'(8'h03));
      check("bp_valid_hold", 32'(bus.out_valid), 32'(1));
      check("bp_in_ready_low", 32'(bus.in_ready), 32'(0));
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    issue(8'hAA, 8'hFF, 4'd9, w);
    check("bp_xor_result", 32'(bus.ALU_Out), 32'(8'h55));
    check("bp_xor_valid", 32'(bus.out_valid), 32'(1));
    tw = 0;
    repeat (16) begin
      issue(8'($urandom), 8'($urandom), rand_non_mul(), w);
      tw += w;
    end
    check("stream_bubbles", 32'(tw), 32'(0));
    rand_bp = 1'b1;
    repeat (40) issue(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)), w);
    rand_bp = 1'b0;
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_random", 32'(sb.size()), 32'(0));
    @(posedge clk);
    #1;
    issue(8'h12, 8'h34, 4'd2, w);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    sb.delete();
    check("abort_out_valid", 32'(bus.out_valid), 32'(0));
    check("abort_outputs", 32'(cur()), 32'(0));
    check("abort_in_ready", 32'(bus.in_ready), 32'(1));
    issue(8'h01, 8'h02, 4'd0, w);
    check("post_abort_add", 32'(bus.ALU_Out), 32'(8'h03));
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_final", 32'(sb.size()), 32'(0));
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
